// File: rtl/aes_package.sv
// rtl/aes_package.sv - shared widths, FSM state types and status flags for the AES gearbox
// Purpose: common definitions imported by aes_block_gearbox and aes_word_serializer.
// Ports: none (package).
package aes_package;

  localparam int AES_WORD_W  = 32;
  localparam int AES_BLOCK_W = 128;
  localparam int AES_CNT_W   = 16;

  typedef enum logic [1:0] {
    PK_IDLE,
    PK_FILL,
    PK_HOLD
  } aes_pack_state_t;

  typedef enum logic [1:0] {
    UP_IDLE,
    UP_EMPTY,
    UP_DRAIN
  } aes_unpack_state_t;

  typedef struct packed {
    logic busy;
    logic done;
  } flags_gearbox_t;

endpackage

// File: rtl/aes_word_serializer.sv
// rtl/aes_word_serializer.sv - splits each ciphertext block into words for the sink streamer
// Purpose: captures one engine block, emits it word 0 first, counts drained blocks.
// Ports:
//   clk, reset, clear          clock, async active-high reset, sync clear
//   start_i                    accepted non-empty job start
//   n_blocks_i                 latched job length
//   ct_blk_i/ct_valid_i/ct_ready_o   block handshake from the engine
//   ct_data_o/ct_valid_o/ct_ready_i  word handshake to the sink
//   job_end_o                  high on the edge that drains the last word of the job
module aes_word_serializer
  import aes_package::*;
#(
  parameter int WORD_W  = AES_WORD_W,
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int CNT_W   = AES_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   n_blocks_i,
  input  logic [BLOCK_W-1:0] ct_blk_i,
  input  logic               ct_valid_i,
  output logic               ct_ready_o,
  output logic [WORD_W-1:0]  ct_data_o,
  output logic               ct_valid_o,
  input  logic               ct_ready_i,
  output logic               job_end_o
);

  localparam int WORDS  = BLOCK_W / WORD_W;
  localparam int RCNT_W = $clog2(WORDS);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(WORDS - 1);
  localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  aes_unpack_state_t  r_state;
  aes_unpack_state_t  w_state_nxt;
  logic [RCNT_W-1:0]  r_rcnt;
  logic [BLOCK_W-1:0] r_blk;
  logic [CNT_W-1:0]   r_blocks_out;

  logic w_ct_take;
  logic w_word_take;
  logic w_blk_last;
  logic w_job_last;

  assign w_ct_take   = (r_state == UP_EMPTY) && ct_valid_i;
  assign w_word_take = (r_state == UP_DRAIN) && ct_ready_i;
  assign w_blk_last  = w_word_take && (r_rcnt == RCNT_LAST);
  assign w_job_last  = w_blk_last && ((r_blocks_out + CNT_ONE) == n_blocks_i);

  assign ct_ready_o = (r_state == UP_EMPTY);
  assign ct_valid_o = (r_state == UP_DRAIN);
  assign ct_data_o  = ct_valid_o ? r_blk[r_rcnt*WORD_W +: WORD_W] : '0;
  assign job_end_o  = w_job_last;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      UP_IDLE:  if (start_i) w_state_nxt = UP_EMPTY;
      UP_EMPTY: if (w_ct_take) w_state_nxt = UP_DRAIN;
      UP_DRAIN: if (w_blk_last) w_state_nxt = w_job_last ? UP_IDLE : UP_EMPTY;
      default:  w_state_nxt = UP_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= UP_IDLE;
      r_rcnt       <= '0;
      r_blk        <= '0;
      r_blocks_out <= '0;
    end else if (clear) begin
      r_state      <= UP_IDLE;
      r_rcnt       <= '0;
      r_blk        <= '0;
      r_blocks_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (start_i) begin
        r_rcnt       <= '0;
        r_blocks_out <= '0;
      end else begin
        if (w_ct_take) begin
          r_blk  <= ct_blk_i;
          r_rcnt <= '0;
        end
        if (w_word_take) r_rcnt <= r_rcnt + RCNT_ONE;
        if (w_blk_last) r_blocks_out <= r_blocks_out + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/aes_block_gearbox.sv
// rtl/aes_block_gearbox.sv - 32-bit stream to 128-bit AES block width adapter with job counting
// Purpose: packs plaintext words into blocks for the engine, unpacks ciphertext blocks
//          into words for the sink, and pulses done once the job's last word has left.
// Ports:
//   clk, reset, clear                     clock, async active-high reset, sync clear
//   start_i, n_blocks_i                   job start pulse and job length
//   pt_data_i/pt_valid_i/pt_ready_o       plaintext words in
//   blk_data_o/blk_valid_o/blk_ready_i    packed blocks to the engine
//   ct_blk_i/ct_valid_i/ct_ready_o        ciphertext blocks from the engine
//   ct_data_o/ct_valid_o/ct_ready_i       ciphertext words out
//   busy_o, done_o                        job active, one-cycle completion pulse
module aes_block_gearbox
  import aes_package::*;
#(
  parameter int WORD_W  = AES_WORD_W,
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int CNT_W   = AES_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               start_i,
  input  logic [CNT_W-1:0]   n_blocks_i,
  input  logic [WORD_W-1:0]  pt_data_i,
  input  logic               pt_valid_i,
  output logic               pt_ready_o,
  output logic [BLOCK_W-1:0] blk_data_o,
  output logic               blk_valid_o,
  input  logic               blk_ready_i,
  input  logic [BLOCK_W-1:0] ct_blk_i,
  input  logic               ct_valid_i,
  output logic               ct_ready_o,
  output logic [WORD_W-1:0]  ct_data_o,
  output logic               ct_valid_o,
  input  logic               ct_ready_i,
  output logic               busy_o,
  output logic               done_o
);

  localparam int WORDS  = BLOCK_W / WORD_W;
  localparam int WCNT_W = $clog2(WORDS);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WORDS - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  aes_pack_state_t    r_pk_state;
  aes_pack_state_t    w_pk_nxt;
  flags_gearbox_t     r_flags;
  logic [CNT_W-1:0]   r_n_blocks;
  logic [CNT_W-1:0]   r_blocks_in;
  logic [WCNT_W-1:0]  r_wcnt;
  logic [BLOCK_W-1:0] r_blk;

  logic w_start;
  logic w_start_job;
  logic w_pt_take;
  logic w_blk_take;
  logic w_pk_last;
  logic w_job_end;

  // While busy both FSMs are mid-job, so a start can only land when they are idle.
  assign w_start     = start_i && !r_flags.busy;
  assign w_start_job = w_start && (n_blocks_i != '0);
  assign w_pt_take   = (r_pk_state == PK_FILL) && pt_valid_i;
  assign w_blk_take  = (r_pk_state == PK_HOLD) && blk_ready_i;
  assign w_pk_last   = w_blk_take && ((r_blocks_in + CNT_ONE) == r_n_blocks);

  assign pt_ready_o  = (r_pk_state == PK_FILL);
  assign blk_valid_o = (r_pk_state == PK_HOLD);
  assign blk_data_o  = r_blk;
  assign busy_o      = r_flags.busy;
  assign done_o      = r_flags.done;

  always_comb begin
    w_pk_nxt = r_pk_state;
    case (r_pk_state)
      PK_IDLE: if (w_start_job) w_pk_nxt = PK_FILL;
      PK_FILL: if (w_pt_take && (r_wcnt == WCNT_LAST)) w_pk_nxt = PK_HOLD;
      PK_HOLD: if (w_blk_take) w_pk_nxt = w_pk_last ? PK_IDLE : PK_FILL;
      default: w_pk_nxt = PK_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pk_state  <= PK_IDLE;
      r_flags     <= '0;
      r_n_blocks  <= '0;
      r_blocks_in <= '0;
      r_wcnt      <= '0;
      r_blk       <= '0;
    end else if (clear) begin
      r_pk_state  <= PK_IDLE;
      r_flags     <= '0;
      r_n_blocks  <= '0;
      r_blocks_in <= '0;
      r_wcnt      <= '0;
      r_blk       <= '0;
    end else begin
      r_pk_state   <= w_pk_nxt;
      r_flags.done <= 1'b0;
      if (w_start) begin
        r_n_blocks  <= n_blocks_i;
        r_blocks_in <= '0;
        r_wcnt      <= '0;
        // An empty job completes immediately without ever raising busy.
        if (n_blocks_i == '0) r_flags.done <= 1'b1;
        else                  r_flags.busy <= 1'b1;
      end else begin
        if (w_pt_take) begin
          r_blk[r_wcnt*WORD_W +: WORD_W] <= pt_data_i;
          r_wcnt <= r_wcnt + WCNT_ONE;
        end
        if (w_blk_take) r_blocks_in <= r_blocks_in + CNT_ONE;
        if (w_job_end) begin
          r_flags.busy <= 1'b0;
          r_flags.done <= 1'b1;
        end
      end
    end
  end

  aes_word_serializer #(
    .WORD_W  (WORD_W),
    .BLOCK_W (BLOCK_W),
    .CNT_W   (CNT_W)
  ) u_serializer (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .start_i    (w_start_job),
    .n_blocks_i (r_n_blocks),
    .ct_blk_i   (ct_blk_i),
    .ct_valid_i (ct_valid_i),
    .ct_ready_o (ct_ready_o),
    .ct_data_o  (ct_data_o),
    .ct_valid_o (ct_valid_o),
    .ct_ready_i (ct_ready_i),
    .job_end_o  (w_job_end)
  );

endmodule

// File: doc/aes_block_gearbox.md
Name: aes_block_gearbox

Overview:
- Width-adaptation stage between the 32-bit HWPE streamers and the 128-bit AES engine core.
- Packs four plaintext words from the source streamer into one 128-bit block for the engine.
- Serialises each 128-bit ciphertext block from the engine into four words for the sink streamer.
- Counts blocks per job and pulses done when the programmed number of ciphertext blocks has left.

Parameters:
- WORD_W, 32, streamer word width.
- BLOCK_W, 128, AES block width; WORDS = BLOCK_W/WORD_W = 4.
- CNT_W, 16, block-counter width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- clear  in  1  synchronous clear: all state to idle, counters to 0
- start_i  in  1  job start pulse; latches n_blocks_i
- n_blocks_i  in  CNT_W  blocks in the job
- pt_data_i  in  WORD_W  plaintext word
- pt_valid_i  in  1  plaintext valid
- pt_ready_o  out  1  plaintext ready
- blk_data_o  out  BLOCK_W  packed block to engine
- blk_valid_o  out  1  block valid
- blk_ready_i  in  1  engine accepts block
- ct_blk_i  in  BLOCK_W  ciphertext block from engine
- ct_valid_i  in  1  ciphertext valid
- ct_ready_o  out  1  gearbox accepts ciphertext block
- ct_data_o  out  WORD_W  ciphertext word to sink
- ct_valid_o  out  1  ciphertext word valid
- ct_ready_i  in  1  sink accepts word
- busy_o  out  1  job active
- done_o  out  1  one-cycle done pulse

Behaviour:
- Reset (async, active-high) and clear force the following: all outputs 0, both FSMs idle, counters 0, data registers 0.
- Transfer rule: a transfer occurs on any clk edge where valid && ready. Valid, once high, holds until the transfer. Data is stable while valid is high.
- Word order: the first word occupies bits [31:0], the fourth word occupies [127:96]. Unpacking uses the same order.
- start_i is accepted only when busy_o = 0; it is ignored otherwise.
- n_blocks_i = 0 at start: no transfers, busy_o stays 0, done_o pulses on the next cycle.
- Otherwise busy_o = 1 from the cycle after start until the cycle done_o pulses.
- Pack FSM states are PK_IDLE, PK_FILL and PK_HOLD.
  - PK_IDLE -> PK_FILL on an accepted start.
  - PK_FILL: pt_ready_o = 1. Each transfer writes word[wcnt] and increments wcnt (2 bits, wraps 3 -> 0). The 4th transfer moves to PK_HOLD.
  - PK_HOLD: blk_valid_o = 1 from the cycle after the 4th word. pt_ready_o = 0; there is no overlap buffer.
  - On the block transfer, blocks_in increments. If blocks_in reaches n_blocks, go to PK_IDLE; otherwise go to PK_FILL.
  - Minimum cost is 5 cycles per block.
- Unpack FSM states are UP_IDLE, UP_EMPTY and UP_DRAIN.
  - UP_IDLE -> UP_EMPTY on an accepted start.
  - UP_EMPTY: ct_ready_o = 1. A transfer captures ct_blk_i and moves to UP_DRAIN with rcnt = 0.
  - UP_DRAIN: ct_valid_o = 1 and ct_data_o = word[rcnt]. On each sink transfer rcnt increments.
  - On the 4th sink transfer, blocks_out increments. If blocks_out reaches n_blocks, go to UP_IDLE and pulse done_o on the next cycle; otherwise go to UP_EMPTY.
- Engine ciphertext arriving while the unpack FSM is in UP_DRAIN is back-pressured; no data is lost.
- Counters are CNT_W bits and compare for equality with the latched n_blocks. No wrap is possible within one job.
- Precedence when events coincide in one cycle: reset > clear > start > transfers.
- Clear mid-job discards partial blocks. The valids drop at the clearing edge. No done_o is produced.

Decomposition:
- aes_package holds:
  - AES_WORD_W and AES_BLOCK_W.
  - aes_pack_state_t {PK_IDLE, PK_FILL, PK_HOLD}.
  - aes_unpack_state_t {UP_IDLE, UP_EMPTY, UP_DRAIN}.
  - flags_gearbox_t {busy, done}.
- The serialiser side is a natural sub-module, aes_word_serializer: ciphertext capture, rcnt and the sink handshake.

Test Plan:
- Single block: n_blocks=1, then pt words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C with valid continuously high.
  - Required: blk_data_o = 0x0F0E0D0C_0B0A0908_07060504_03020100, with blk_valid_o in the cycle after the 4th word.
  - Required: after the engine returns that block, the sink sees the same 4 words in order, then one done_o pulse.
- Engine stall: hold blk_ready_i low for 10 cycles.
  - Required: blk_valid_o and blk_data_o are stable, and pt_ready_o = 0 throughout.
- Sink stall: ct_ready_i toggles 1,0,0,1,…
  - Required: every word is emitted exactly once, in order, and ct_ready_o = 0 until the 4th word is accepted.
- Three-block job: n_blocks=3 with 12 words fed.
  - Required: 3 block transfers and 12 sink words, and done_o pulses only after the 12th word.
  - Required: start_i issued mid-job is ignored.
- Clear after 2 plaintext words.
  - Required: all valids drop next cycle, busy_o = 0, and no done_o.
  - Required: a new 1-block job then packs correctly starting from word 0.
- Zero blocks: n_blocks=0.
  - Required: done_o pulses one cycle after start, busy_o stays 0, and no ready or valid is asserted.
